// File: rtl/param_loader_pkg.sv
// Shared types and helpers for the neuron parameter-chain loader.
// The optional CRC block is enabled with PARAM_LOADER_CRC_EN.
package param_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic int total_bits(input int n, input int i, input int b);
        return n * (i + b);
    endfunction

    function automatic int num_bytes(input int n, input int i, input int b);
        return (total_bits(n, i, b) + 7) / 8;
    endfunction

endpackage

// File: rtl/param_loader_if.sv
// Host-side byte handshake into the parameter loader.
// master = host, slave = loader.
interface param_loader_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/param_loader_crc8.sv
// Bit-serial CRC-8 (MSB-first, init 0) with clear and enable.
// Only instantiated when PARAM_LOADER_CRC_EN is defined.
module crc8_serial
    import param_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic fb;

    assign fb = crc[7] ^ din;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/param_loader.sv
// Serial MSB-first transmitter for the neuron parameter chain.
// Define PARAM_LOADER_CRC_EN to add a CRC-8 of the shifted stream.
module param_loader
    import param_loader_pkg::*;
#(
    parameter int NEURONS   = 4,
    parameter int INPUTS    = 8,
    parameter int BIAS_BITS = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    param_loader_if.slave  bus,
    output logic           setup,
    output logic           param_out,
    output logic           busy,
`ifdef PARAM_LOADER_CRC_EN
    output logic [7:0]     crc,
`endif
    output logic           done
);

    localparam int TOTAL = total_bits(NEURONS, INPUTS, BIAS_BITS);
    localparam int RW    = $clog2(TOTAL + 1);

    localparam logic [RW-1:0] TOTAL_R = RW'(TOTAL);
    localparam logic [RW-1:0] ONE_R   = RW'(1);

    state_t        state;
    logic [7:0]    shreg;
    logic [RW-1:0] remaining;
    logic [3:0]    bits_in_byte;
    logic [3:0]    first_bits;

    // Only the upper bits of a final partial byte are sent.
    always_comb begin
        first_bits = 4'd8;
        if (int'(remaining) < 8) begin
            first_bits = 4'(remaining);
        end
    end

    // shreg holds the bits still to follow the one on param_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= 8'h00;
            remaining      <= '0;
            bits_in_byte   <= 4'd0;
            bus.byte_ready <= 1'b0;
            setup          <= 1'b0;
            param_out      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state          <= LOAD;
                        remaining      <= TOTAL_R;
                        bus.byte_ready <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.byte_valid) begin
                        state          <= SHIFT;
                        shreg          <= {bus.byte_in[6:0], 1'b0};
                        param_out      <= bus.byte_in[7];
                        bits_in_byte   <= first_bits;
                        bus.byte_ready <= 1'b0;
                        setup          <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg        <= {shreg[6:0], 1'b0};
                    remaining    <= remaining - ONE_R;
                    bits_in_byte <= bits_in_byte - 4'd1;
                    if (remaining == ONE_R) begin
                        state     <= FINISH;
                        setup     <= 1'b0;
                        param_out <= 1'b0;
                        done      <= 1'b1;
                    end else if (bits_in_byte == 4'd1) begin
                        state          <= LOAD;
                        setup          <= 1'b0;
                        param_out      <= 1'b0;
                        bus.byte_ready <= 1'b1;
                    end else begin
                        param_out <= shreg[7];
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PARAM_LOADER_CRC_EN
    logic start_ok;

    assign start_ok = (state == IDLE) && start;

    crc8_serial u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .en    (setup),
        .din   (param_out),
        .crc   (crc)
    );
`endif

endmodule

// File: tb/tb_param_loader.sv
// Randomized scoreboard bench for param_loader (default and
// PARAM_LOADER_CRC_EN builds).
module tb_param_loader;
    import param_loader_pkg::*;

    localparam int N     = 4;
    localparam int I     = 8;
    localparam int B     = 3;
    localparam int TOTAL = total_bits(N, I, B);
    localparam int NB    = num_bytes(N, I, B);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic setup;
    logic param_out;
    logic busy;
    logic done;
`ifdef PARAM_LOADER_CRC_EN
    logic [7:0] crc;
`endif

    param_loader_if bus ();

    param_loader #(
        .NEURONS   (N),
        .INPUTS    (I),
        .BIAS_BITS (B)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .setup     (setup),
        .param_out (param_out),
        .busy      (busy),
`ifdef PARAM_LOADER_CRC_EN
        .crc       (crc),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    bit exp_q[$];
    bit sent[$];
    int n_pass = 0;
    int n_total = 0;
    int setup_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // CRC as remainder of (message * x^8) divided by x^8+x^2+x+1.
    function automatic int crc_model();
        logic [8:0] r;
        r = 9'h000;
        foreach (sent[k]) begin
            r = {r[7:0], sent[k]};
            if (r[8]) r = r ^ 9'h107;
        end
        for (int k = 0; k < 8; k++) begin
            r = {r[7:0], 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return int'(r[7:0]);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (setup) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_setup", 1, 0);
                end else begin
                    chk("param_out", int'(param_out), int'(exp_q.pop_front()));
                end
                setup_cnt++;
            end else begin
                chk("param_out_idle", int'(param_out), 0);
            end
            if (done) begin
                done_cnt++;
                chk("setup_count", setup_cnt, TOTAL);
                chk("queue_drained", exp_q.size(), 0);
                chk("busy_at_done", int'(busy), 1);
`ifdef PARAM_LOADER_CRC_EN
                chk("crc", int'(crc), crc_model());
`endif
                setup_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int k);
        int  waited;
        bit  acc;
        int  nbits;
        waited = 0;
        acc = 1'b0;
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        while (!acc && waited < 40) begin
            @(posedge clk);
            if (bus.byte_ready) acc = 1'b1;
            waited++;
            #1;
        end
        if (acc) begin
            nbits = (TOTAL - 8 * k < 8) ? TOTAL - 8 * k : 8;
            for (int j = 0; j < nbits; j++) begin
                exp_q.push_back(b[7-j]);
                sent.push_back(b[7-j]);
            end
        end else begin
            chk("handshake_timeout", 0, 1);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        sent.delete();
        chk("busy_after_start", int'(busy), 1);
        chk("ready_in_load", int'(bus.byte_ready), 1);
    endtask

    task automatic run_load(input int max_stall, input bit poke,
                            input int gap_byte, input int gap_len);
        int d0;
        int st;
        int w;
        d0 = done_cnt;
        do_start();
        for (int k = 0; k < NB; k++) begin
            st = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
            if (k == gap_byte) st = 8 + gap_len;
            if (st > 0 && k > 0) begin
                bus.byte_valid = 1'b0;
                bus.byte_in = 8'($urandom);
                repeat (st) begin
                    if (poke) start = 1'b1;
                    tick();
                    start = 1'b0;
                end
            end
            send_byte(8'($urandom), k);
        end
        bus.byte_valid = 1'b0;
        w = 0;
        while (done_cnt == d0 && w < 30) begin
            if (poke) start = 1'b1;
            tick();
            start = 1'b0;
            w++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("busy_after_done", int'(busy), 0);
        chk("ready_after_done", int'(bus.byte_ready), 0);
        repeat (10) tick();
        chk("single_done", done_cnt - d0, 1);
`ifdef PARAM_LOADER_CRC_EN
        chk("crc_stable", int'(crc), crc_model());
`endif
    endtask

    initial begin
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        chk("rst_setup", int'(setup), 0);
        chk("rst_param_out", int'(param_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(bus.byte_ready), 0);
        reset = 1'b0;
        tick();

        run_load(0, 1'b0, -1, 0);
        run_load(0, 1'b0, 2, 5);

        do_start();
`ifdef PARAM_LOADER_CRC_EN
        chk("crc_cleared", int'(crc), 0);
`endif
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 1);
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_setup", int'(setup), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(bus.byte_ready), 0);
        exp_q.delete();
        setup_cnt = 0;
        tick();

        run_load(0, 1'b0, -1, 0);
        run_load(6, 1'b1, -1, 0);
        for (int r = 0; r < 4; r++) begin
            run_load(14, r[0], -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
